// File: rtl/dcache_nway_wb.sv
// Write-back, write-allocate set-associative data cache with tree-PLRU replacement,
// multi-beat refill/writeback, an uncached MMIO bypass and a full-cache flush walk.
module dcache_nway_wb #(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [2:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              req_ready,
  output logic [63:0]       req_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata
);
  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int LVL     = $clog2(WAYS);
  localparam int WB_B    = (WORD_W > 0) ? WORD_W : 1;
  localparam int IDX_B   = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_B   = (LVL > 0) ? LVL : 1;
  localparam int PL_W    = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int TAG_W   = ADDR_W - 3 - WORD_W - IDX_W;
  localparam int SH_IDX  = 3 + WORD_W;
  localparam int SH_TAG  = 3 + WORD_W + IDX_W;
  localparam int ENTRIES = WAYS * SETS;
  localparam int CNT_W   = $clog2(ENTRIES) + 1;

  typedef enum logic [2:0] {IDLE, HIT, WB, FILL, REPLY, UNC, FL_SCAN, FL_WB} state_t;

  state_t             state_q, state_d;
  logic [WB_B-1:0]    beat_q, beat_d;
  logic [WAY_B-1:0]   way_q, way_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAYS-1:0]    vld_q [SETS];
  logic [WAYS-1:0]    vld_d [SETS];
  logic [WAYS-1:0]    dty_q [SETS];
  logic [WAYS-1:0]    dty_d [SETS];
  logic [PL_W-1:0]    plru_q [SETS];
  logic [PL_W-1:0]    plru_d [SETS];
  logic [TAG_W-1:0]   tag_q [WAYS][SETS];
  logic [TAG_W-1:0]   tag_d [WAYS][SETS];
  logic [63:0]        data_q [WAYS][SETS][LINE_WORDS];
  logic [63:0]        data_d [WAYS][SETS][LINE_WORDS];

  logic [WB_B-1:0]    req_word;
  logic [IDX_B-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req_unc;
  logic               hit, free_found;
  logic [WAY_B-1:0]   hit_way, vic_way;
  logic [WAY_B-1:0]   fl_way;
  logic [IDX_B-1:0]   fl_set;
  logic               last_beat;

  assign req_word  = WB_B'(req_addr >> 3) & WB_B'(LINE_WORDS - 1);
  assign req_idx   = IDX_B'(req_addr >> SH_IDX) & IDX_B'(SETS - 1);
  assign req_tag   = TAG_W'(req_addr >> SH_TAG);
  assign req_unc   = ~req_addr[ADDR_W-1];
  assign fl_set    = IDX_B'(cnt_q) & IDX_B'(SETS - 1);
  assign fl_way    = WAY_B'(cnt_q >> IDX_W) & WAY_B'(WAYS - 1);
  assign last_beat = (beat_q == WB_B'(LINE_WORDS - 1));

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_B-1:0] i,
                                                  input logic [WB_B-1:0] b);
    line_addr = (ADDR_W'(t) << SH_TAG) | (ADDR_W'(i) << SH_IDX) | (ADDR_W'(b) << 3);
  endfunction

  // Tree bits point at the LRU half; node n has children 2n+1 (left) and 2n+2 (right).
  function automatic logic [WAY_B-1:0] plru_victim(input logic [PL_W-1:0] bits);
    int node;
    logic b;
    node = 0;
    plru_victim = '0;
    for (int l = 0; l < LVL; l++) begin
      b = bits[node];
      plru_victim = WAY_B'({plru_victim, b});
      node = 2 * node + 1 + int'(b);
    end
  endfunction

  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] bits,
                                                 input logic [WAY_B-1:0] way);
    int node;
    logic b;
    node = 0;
    plru_touch = bits;
    for (int l = 0; l < LVL; l++) begin
      b = way[LVL-1-l];
      plru_touch[node] = ~b;
      node = 2 * node + 1 + int'(b);
    end
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] be;
    case (sz)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0f;
      default: be = 8'hff;
    endcase
    be = be << off;
    for (int b = 0; b < 8; b++) store_merge[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
  endfunction

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    vic_way    = plru_victim(plru_q[req_idx]);
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && vld_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_B'(w);
      end
      if (!free_found && !vld_q[req_idx][w]) begin
        free_found = 1'b1;
        vic_way    = WAY_B'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    way_d      = way_q;
    cnt_d      = cnt_q;
    vld_d      = vld_q;
    dty_d      = dty_q;
    plru_d     = plru_q;
    tag_d      = tag_q;
    data_d     = data_q;
    req_ready  = 1'b0;
    req_rdata  = '0;
    flush_done = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_size   = 3'b011;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          cnt_d   = '0;
          state_d = FL_SCAN;
        end else if (req_valid) begin
          beat_d = '0;
          if (req_unc) state_d = UNC;
          else if (hit) begin
            way_d   = hit_way;
            state_d = HIT;
          end else begin
            way_d   = vic_way;
            state_d = (vld_q[req_idx][vic_way] && dty_q[req_idx][vic_way]) ? WB : FILL;
          end
        end
      end
      HIT, REPLY: begin
        req_ready = 1'b1;
        req_rdata = data_q[way_q][req_idx][req_word];
        if (req_wen) begin
          data_d[way_q][req_idx][req_word] = store_merge(data_q[way_q][req_idx][req_word],
                                                         req_wdata, req_size[1:0], req_addr[2:0]);
          dty_d[req_idx][way_q] = 1'b1;
        end
        plru_d[req_idx] = plru_touch(plru_q[req_idx], way_q);
        state_d = IDLE;
      end
      WB: begin
        mem_valid = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = line_addr(tag_q[way_q][req_idx], req_idx, beat_q);
        mem_wdata = data_q[way_q][req_idx][beat_q];
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            beat_d = '0;
            dty_d[req_idx][way_q] = 1'b0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_valid = 1'b1;
        mem_addr  = line_addr(req_tag, req_idx, beat_q);
        if (mem_ready) begin
          data_d[way_q][req_idx][beat_q] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            beat_d = '0;
            vld_d[req_idx][way_q] = 1'b1;
            tag_d[way_q][req_idx] = req_tag;
            state_d = REPLY;
          end
        end
      end
      UNC: begin
        mem_valid = 1'b1;
        mem_wen   = req_wen;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_size  = req_size;
        if (mem_ready) begin
          req_ready = 1'b1;
          req_rdata = mem_rdata;
          state_d   = IDLE;
        end
      end
      FL_SCAN: begin
        // One extra scan step past the last entry finishes the walk.
        if (cnt_q == CNT_W'(ENTRIES)) begin
          for (int s = 0; s < SETS; s++) begin
            vld_d[s]  = '0;
            dty_d[s]  = '0;
            plru_d[s] = '0;
          end
          flush_done = 1'b1;
          state_d    = IDLE;
        end else if (vld_q[fl_set][fl_way] && dty_q[fl_set][fl_way]) begin
          beat_d  = '0;
          state_d = FL_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FL_WB: begin
        mem_valid = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = line_addr(tag_q[fl_way][fl_set], fl_set, beat_q);
        mem_wdata = data_q[fl_way][fl_set][beat_q];
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            beat_d = '0;
            dty_d[fl_set][fl_way] = 1'b0;
            cnt_d   = cnt_q + 1'b1;
            state_d = FL_SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        vld_q[s]  <= '0;
        dty_q[s]  <= '0;
        plru_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dty_q   <= dty_d;
      plru_q  <= plru_d;
    end
  end

  // Tags and data are only meaningful under V, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_dcache_nway_wb.sv
// Bench for dcache_nway_wb: vector table of LSU accesses against an architectural
// memory model, plus flush and reset-during-refill sequences.
module tb_dcache_nway_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_wen, req_ready, flush_req, flush_done;
  logic [31:0] req_addr, mem_addr;
  logic [2:0]  req_size, mem_size;
  logic [63:0] req_wdata, req_rdata, mem_wdata, mem_rdata;
  logic        mem_valid, mem_wen, mem_ready;

  dcache_nway_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wen(req_wen), .req_size(req_size),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
  } beat_t;
  beat_t beat_log[$];

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  size;
    logic [63:0] wdata;
    int          lat;
    int          beats;
    int          wr;
    logic [31:0] a0;
    logic [31:0] alast;
    logic [2:0]  sz0;
  } vec_t;
  vec_t tbl[17];

  logic [63:0] back_mem [logic [31:0]];
  logic [63:0] arch_mem [logic [31:0]];
  int mem_dly = 0;
  int wait_cnt = 0;
  bit mem_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_default(input logic [31:0] al);
    return {al ^ 32'hC0DE_0000, ~al};
  endfunction

  function automatic logic [63:0] apply_store(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [2:0] sz, input logic [2:0] off);
    int n;
    logic [63:0] r;
    n = 1 << sz[1:0];
    r = old;
    for (int b = 0; b < 8; b++)
      if (b >= int'(off) && b < int'(off) + n) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] back_rd(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:3], 3'b000};
    if (back_mem.exists(al)) return back_mem[al];
    return mem_default(al);
  endfunction

  function automatic logic [63:0] arch_rd(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:3], 3'b000};
    if (arch_mem.exists(al)) return arch_mem[al];
    return mem_default(al);
  endfunction

  // Memory responder: answers each beat after 0..mem_dly idle cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_valid && !rst && !mem_hold) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          beat_log.push_back('{mem_wen, mem_addr, mem_wdata, mem_size});
          if (mem_wen)
            back_mem[{mem_addr[31:3], 3'b000}] = apply_store(back_rd(mem_addr), mem_wdata,
                                                             mem_size, mem_addr[2:0]);
          else mem_rdata = back_rd(mem_addr);
          mem_ready = 1'b1;
          wait_cnt = $urandom_range(0, mem_dly);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completion pulse.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [63:0] wd, output int lat);
    int cyc;
    bit got;
    beat_log.delete();
    if (!w) exp_q.push_back(arch_rd(a));
    else arch_mem[{a[31:3], 3'b000}] = apply_store(arch_rd(a), wd, sz, a[2:0]);
    req_addr = a; req_wen = w; req_size = sz; req_wdata = wd; req_valid = 1'b1;
    cyc = 0; got = 0; lat = -1;
    while (!got && cyc < 300) begin
      @(negedge clk); #2;
      cyc++;
      if (req_ready) begin
        got = 1;
        lat = cyc - 1;
        if (!w) begin
          chk("rdata_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) chk($sformatf("rdata@%h", a), req_rdata, exp_q.pop_front());
        end
      end
    end
    if (!got) begin
      chk($sformatf("req_ready_seen@%h", a), 64'd0, 64'd1);
      if (!w && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  function automatic beat_t log_at(input int k);
    beat_t z;
    z = '{1'b0, 32'h0, 64'h0, 3'h0};
    if (k >= 0 && k < beat_log.size()) return beat_log[k];
    return z;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat, pulses, wr;
    bit done, seen;
    logic [31:0] fl_exp[4];
    beat_t bt;

    req_valid = 0; req_addr = '0; req_wen = 0; req_size = '0; req_wdata = '0; flush_req = 0;
    fl_exp[0] = 32'h8000_0040; fl_exp[1] = 32'h8000_0048;
    fl_exp[2] = 32'h8000_0480; fl_exp[3] = 32'h8000_0488;

    //          addr          wen   sz    wdata                  lat bt wr a0            alast         sz0
    tbl[0]  = '{32'h8000_0040, 1'b0, 3'd3, 64'h0,                 3, 2, 0, 32'h8000_0040, 32'h8000_0048, 3'd3};
    tbl[1]  = '{32'h8000_0040, 1'b0, 3'd3, 64'h0,                 1, 0, 0, 32'h0,         32'h0,         3'd0};
    tbl[2]  = '{32'h8000_0048, 1'b0, 3'd3, 64'h0,                 1, 0, 0, 32'h0,         32'h0,         3'd0};
    tbl[3]  = '{32'h8000_0043, 1'b1, 3'd0, 64'h0000_0000_AB00_0000, 1, 0, 0, 32'h0,       32'h0,         3'd0};
    tbl[4]  = '{32'h8000_0040, 1'b0, 3'd3, 64'h0,                 1, 0, 0, 32'h0,         32'h0,         3'd0};
    tbl[5]  = '{32'h8000_004A, 1'b1, 3'd1, 64'h0000_0000_BEEF_0000, 1, 0, 0, 32'h0,       32'h0,         3'd0};
    tbl[6]  = '{32'h8000_004C, 1'b0, 3'd2, 64'h0,                 1, 0, 0, 32'h0,         32'h0,         3'd0};
    tbl[7]  = '{32'h8000_0080, 1'b1, 3'd3, 64'h1122_3344_5566_7788, 3, 2, 0, 32'h8000_0080, 32'h8000_0088, 3'd3};
    tbl[8]  = '{32'h8000_0480, 1'b0, 3'd3, 64'h0,                 3, 2, 0, 32'h8000_0480, 32'h8000_0488, 3'd3};
    tbl[9]  = '{32'h8000_0880, 1'b0, 3'd3, 64'h0,                 3, 2, 0, 32'h8000_0880, 32'h8000_0888, 3'd3};
    tbl[10] = '{32'h8000_0C80, 1'b0, 3'd3, 64'h0,                 3, 2, 0, 32'h8000_0C80, 32'h8000_0C88, 3'd3};
    tbl[11] = '{32'h8000_1080, 1'b0, 3'd3, 64'h0,                 5, 4, 2, 32'h8000_0080, 32'h8000_1088, 3'd3};
    tbl[12] = '{32'h8000_0080, 1'b0, 3'd3, 64'h0,                 3, 2, 0, 32'h8000_0080, 32'h8000_0088, 3'd3};
    tbl[13] = '{32'h8000_0480, 1'b0, 3'd3, 64'h0,                 1, 0, 0, 32'h0,         32'h0,         3'd0};
    tbl[14] = '{32'h1000_0004, 1'b1, 3'd2, 64'h1234_5678_0000_0000, 1, 1, 1, 32'h1000_0004, 32'h1000_0004, 3'd2};
    tbl[15] = '{32'h1000_0004, 1'b0, 3'd2, 64'h0,                 1, 1, 0, 32'h1000_0004, 32'h1000_0004, 3'd2};
    tbl[16] = '{32'h8000_0040, 1'b0, 3'd3, 64'h0,                 1, 0, 0, 32'h0,         32'h0,         3'd0};

    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      do_req(tbl[i].addr, tbl[i].wen, tbl[i].size, tbl[i].wdata, lat);
      wr = 0;
      foreach (beat_log[k]) if (beat_log[k].wen) wr++;
      chk($sformatf("lat[%0d]", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("beats[%0d]", i), 64'(beat_log.size()), 64'(tbl[i].beats));
      chk($sformatf("wr_beats[%0d]", i), 64'(wr), 64'(tbl[i].wr));
      if (tbl[i].beats > 0) begin
        bt = log_at(0);
        chk($sformatf("first_addr[%0d]", i), 64'(bt.addr), 64'(tbl[i].a0));
        chk($sformatf("first_size[%0d]", i), 64'(bt.size), 64'(tbl[i].sz0));
        bt = log_at(beat_log.size() - 1);
        chk($sformatf("last_addr[%0d]", i), 64'(bt.addr), 64'(tbl[i].alast));
      end
    end

    // Second dirty line, then flush with a slow memory.
    do_req(32'h8000_0480, 1'b1, 3'd3, 64'hCAFE_F00D_0BAD_BEEF, lat);
    chk("store_hit_lat", 64'(lat), 64'd1);
    mem_dly = 3; wait_cnt = 0;
    beat_log.delete();
    flush_req = 1'b1;
    pulses = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk); #2;
      if (flush_done) begin
        pulses++;
        done = 1;
        flush_req = 1'b0;
      end
    end
    flush_req = 1'b0;
    chk("flush_done_seen", 64'(done), 64'd1);
    repeat (20) begin
      @(negedge clk); #2;
      if (flush_done) pulses++;
    end
    chk("flush_done_pulses", 64'(pulses), 64'd1);
    chk("flush_beats", 64'(beat_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      bt = log_at(k);
      chk($sformatf("flush_addr[%0d]", k), 64'(bt.addr), 64'(fl_exp[k]));
      chk($sformatf("flush_wen[%0d]", k), 64'(bt.wen), 64'd1);
      chk($sformatf("flush_wdata[%0d]", k), bt.wdata, arch_rd(fl_exp[k]));
    end
    mem_dly = 0; wait_cnt = 0;
    @(posedge clk); #1;
    do_req(32'h8000_0040, 1'b0, 3'd3, 64'h0, lat);
    chk("post_flush_miss_40", 64'(lat), 64'd3);
    do_req(32'h8000_0480, 1'b0, 3'd3, 64'h0, lat);
    chk("post_flush_miss_480", 64'(lat), 64'd3);

    // Reset in the middle of a refill beat.
    mem_hold = 1;
    req_addr = 32'h8000_2040; req_wen = 0; req_size = 3'd3; req_wdata = '0; req_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      if (mem_valid) seen = 1;
    end
    chk("fill_started", 64'(seen), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_fill_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mid_fill_mem_addr", 64'(mem_addr), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 0; wait_cnt = 0;
    @(posedge clk); #1;
    do_req(32'h8000_0040, 1'b0, 3'd3, 64'h0, lat);
    chk("post_rst_miss_40", 64'(lat), 64'd3);
    do_req(32'h8000_2040, 1'b0, 3'd3, 64'h0, lat);
    chk("post_rst_miss_2040", 64'(lat), 64'd3);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
